cnt_updown: RTL and testbench
=============================

CNT_UPDOWN -- requirements
Module: cnt_updown

Interface
REQ-001 Parameter N, default 4, counter width in bits; legal range 2..32.
REQ-002 Parameter MAX, default 2**N-1, terminal (highest) count value; legal range 1..2**N-1.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 clr  input  1  synchronous clear of count and sticky flag.
REQ-006 load  input  1  synchronous parallel load of d.
REQ-007 d  input  N  load value.
REQ-008 en  input  1  count enable.
REQ-009 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 q  output  N  registered count value.
REQ-011 tc  output  1  combinational terminal-count indicator.
REQ-012 wrap  output  1  registered one-cycle pulse, boundary crossed.
REQ-013 ovf  output  1  registered sticky boundary-event flag.

Function
REQ-014 Per-edge priority: clr > load > en; with none asserted, q holds.
REQ-015 clr=1: q <= 0; ovf <= 0; wrap <= 0.
REQ-016 load=1, clr=0: q <= d if d <= MAX, else q <= MAX; wrap <= 0; ovf unchanged.
REQ-017 en=1, up=1, q<MAX: q <= q+1.
REQ-018 en=1, up=0, q>0: q <= q-1.
REQ-019 en=1, up=1, q==MAX: boundary event; next q per REQ-030/031.
REQ-020 en=1, up=0, q==0: boundary event; next q per REQ-030/031.
REQ-021 wrap is 1 in the cycle after a boundary event, else 0; back-to-back events give wrap high on consecutive cycles.
REQ-022 ovf is set on the same edge that sets wrap; it stays set until clr or reset.
REQ-023 tc = en & ((up & q==MAX) | (~up & q==0)); tc is combinational and does not depend on clr or load.
REQ-024 A direction change takes effect on the next enabled edge, with no dead cycle.
REQ-025 q never exceeds MAX after any edge, including after load.
REQ-026 Count arithmetic is N-bit unsigned; no intermediate wider than N+1 bits is visible at any output.

Reset
REQ-027 resetn=0: q=0, wrap=0, ovf=0 immediately, independent of Clk.
REQ-028 Reset asserted mid-count aborts the operation; after release, the first rising edge applies REQ-014 normally.
REQ-029 tc follows REQ-023 during reset, evaluated with q=0.

Configuration
REQ-030 Macro CNT_UPDOWN_SAT_EN undefined (default): wrap-around mode; an up boundary event gives q <= 0, a down boundary event gives q <= MAX.
REQ-031 Macro CNT_UPDOWN_SAT_EN defined: saturating mode; on a boundary event q holds (MAX or 0); wrap and ovf still assert per REQ-021/022.

Verification
REQ-032 N=4, MAX=9, wrap mode: reset, en=1, up=1 for 12 edges -> q 1..9,0,1,2; tc=1 while q=9; wrap=1 exactly one cycle, with q=0; ovf=1 thereafter.
REQ-033 N=4, MAX=9, wrap mode: from q=0, en=1, up=0, one edge -> q=9, wrap pulse, ovf=1; then clr=1 -> q=0, ovf=0.
REQ-034 N=4, MAX=9, CNT_UPDOWN_SAT_EN defined: up-count from q=8 for 3 edges -> q=9,9,9; wrap high for 2 consecutive cycles; ovf=1.
REQ-035 Priority: clr=1, load=1, d=5, en=1 on the same edge -> q=0; then load=1, d=15, en=1 -> q=9 (clamped, no count); then load=1, d=3 -> q=3.
REQ-036 Async reset: resetn deasserted mid-cycle at q=6 with ovf=1 -> q=0 and ovf=0 before the next edge; counting resumes from 0 on the first edge after release.
REQ-037 Direction flip: q=4, up toggled 1,0,1,0 on successive enabled edges -> q=5,4,5,4; wrap never asserted.

Source files
------------

// File: rtl/cnt_updown.sv
// Up/down counter with clamped parallel load, terminal-count flag, wrap pulse and sticky ovf.
// Define CNT_UPDOWN_SAT_EN to saturate at the boundaries instead of wrapping around.
module cnt_updown #(
    parameter int unsigned     N   = 4,
    parameter logic [N-1:0]    MAX = {N{1'b1}}
) (
    input  logic         Clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] d,
    input  logic         en,
    input  logic         up,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         wrap,
    output logic         ovf
);

    logic [N-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         ovf_q, ovf_d;
    logic         atMax, atZero, boundary;

    assign atMax    = (count_q == MAX);
    assign atZero   = (count_q == '0);
    assign boundary = en & ((up & atMax) | (~up & atZero));

    // Priority clr > load > en; a load value above MAX is clamped so q never leaves range.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            count_d = (d > MAX) ? MAX : d;
        end else if (en) begin
            if (boundary) begin
                wrap_d = 1'b1;
                ovf_d  = 1'b1;
`ifdef CNT_UPDOWN_SAT_EN
                count_d = count_q;
`else
                count_d = up ? '0 : MAX;
`endif
            end else if (up) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign q    = count_q;
    assign tc   = boundary;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cnt_updown.sv
// Directed self-checking bench for cnt_updown with N=4, MAX=9.
// Boundary expectations follow CNT_UPDOWN_SAT_EN when the bench is built with it.
module tb_cnt_updown;

    localparam int N = 4;
    localparam logic [N-1:0] MAX = 4'd9;
`ifdef CNT_UPDOWN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         resetn;
    logic         clr, load, en, up;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         tc, wrap, ovf;

    int checks = 0;
    int errors = 0;

    cnt_updown #(.N(N), .MAX(MAX)) dut (
        .Clk(Clk), .resetn(resetn), .clr(clr), .load(load), .d(d),
        .en(en), .up(up), .q(q), .tc(tc), .wrap(wrap), .ovf(ovf)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; clr = 0; load = 0; en = 0; up = 0; d = '0;
        #3;
        checks++; if (q !== 4'd0) begin errors++; $display("[TB] FAIL reset_q got %0d expected 0", q); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap got %0b expected 0", wrap); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %0b expected 0", ovf); end
        checks++; if (tc !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc_idle got %0b expected 0", tc); end
        en = 1; up = 0;
        #1;
        checks++; if (tc !== 1'b1) begin errors++; $display("[TB] FAIL reset_tc_down got %0b expected 1", tc); end
        en = 0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_count_up();
        logic [N-1:0] expQ = '0;
        logic         expOvf = 1'b0;
        logic         bnd;
        en = 1; up = 1;
        for (int i = 1; i <= 12; i++) begin
            #1;
            bnd = (expQ == MAX);
            checks++; if (tc !== bnd) begin errors++; $display("[TB] FAIL up_tc step %0d got %0b expected %0b", i, tc, bnd); end
            tick();
            expQ = bnd ? (SAT ? MAX : 4'd0) : expQ + 4'd1;
            if (bnd) expOvf = 1'b1;
            checks++; if (q !== expQ) begin errors++; $display("[TB] FAIL up_q step %0d got %0d expected %0d", i, q, expQ); end
            checks++; if (wrap !== bnd) begin errors++; $display("[TB] FAIL up_wrap step %0d got %0b expected %0b", i, wrap, bnd); end
            checks++; if (ovf !== expOvf) begin errors++; $display("[TB] FAIL up_ovf step %0d got %0b expected %0b", i, ovf, expOvf); end
        end
        en = 0;
    endtask

    task automatic test_count_down_clear();
        clr = 1;
        tick();
        clr = 0;
        checks++; if (q !== 4'd0 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL dn_preclr got q=%0d ovf=%0b expected q=0 ovf=0", q, ovf); end
        en = 1; up = 0;
        tick();
        en = 0;
        checks++; if (q !== (SAT ? 4'd0 : 4'd9)) begin errors++; $display("[TB] FAIL dn_q got %0d expected %0d", q, SAT ? 0 : 9); end
        checks++; if (wrap !== 1'b1) begin errors++; $display("[TB] FAIL dn_wrap got %0b expected 1", wrap); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL dn_ovf got %0b expected 1", ovf); end
        clr = 1;
        tick();
        clr = 0;
        checks++; if (q !== 4'd0 || ovf !== 1'b0 || wrap !== 1'b0) begin errors++; $display("[TB] FAIL dn_clr got q=%0d ovf=%0b wrap=%0b expected 0 0 0", q, ovf, wrap); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] expQ [3];
        logic         expW [3];
        if (SAT) begin
            expQ = '{4'd9, 4'd9, 4'd9}; expW = '{1'b0, 1'b1, 1'b1};
        end else begin
            expQ = '{4'd9, 4'd0, 4'd1}; expW = '{1'b0, 1'b1, 1'b0};
        end
        load = 1; d = 4'd8;
        tick();
        load = 0;
        checks++; if (q !== 4'd8) begin errors++; $display("[TB] FAIL b2b_load got %0d expected 8", q); end
        en = 1; up = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q !== expQ[i]) begin errors++; $display("[TB] FAIL b2b_q step %0d got %0d expected %0d", i, q, expQ[i]); end
            checks++; if (wrap !== expW[i]) begin errors++; $display("[TB] FAIL b2b_wrap step %0d got %0b expected %0b", i, wrap, expW[i]); end
        end
        en = 0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ovf got %0b expected 1", ovf); end
    endtask

    task automatic test_priority();
        clr = 1; load = 1; d = 4'd5; en = 1; up = 1;
        tick();
        clr = 0;
        checks++; if (q !== 4'd0 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL prio_clr got q=%0d ovf=%0b expected q=0 ovf=0", q, ovf); end
        up = 0;
        #1;
        checks++; if (tc !== 1'b1) begin errors++; $display("[TB] FAIL prio_tc_load got %0b expected 1", tc); end
        d = 4'd15;
        tick();
        checks++; if (q !== 4'd9 || wrap !== 1'b0 || ovf !== 1'b0) begin errors++; $display("[TB] FAIL prio_clamp got q=%0d wrap=%0b ovf=%0b expected 9 0 0", q, wrap, ovf); end
        en = 0; d = 4'd3;
        tick();
        load = 0;
        checks++; if (q !== 4'd3) begin errors++; $display("[TB] FAIL prio_load got %0d expected 3", q); end
    endtask

    task automatic test_async_reset();
        load = 1; d = 4'd9;
        tick();
        load = 0; en = 1; up = 1;
        tick();
        en = 0; load = 1; d = 4'd6;
        tick();
        load = 0;
        checks++; if (q !== 4'd6 || ovf !== 1'b1) begin errors++; $display("[TB] FAIL arst_pre got q=%0d ovf=%0b expected q=6 ovf=1", q, ovf); end
        #3;
        resetn = 1'b0;
        #1;
        checks++; if (q !== 4'd0 || ovf !== 1'b0 || wrap !== 1'b0) begin errors++; $display("[TB] FAIL arst_async got q=%0d ovf=%0b wrap=%0b expected 0 0 0", q, ovf, wrap); end
        #2;
        resetn = 1'b1;
        en = 1; up = 1;
        tick();
        en = 0;
        checks++; if (q !== 4'd1 || wrap !== 1'b0) begin errors++; $display("[TB] FAIL arst_resume got q=%0d wrap=%0b expected q=1 wrap=0", q, wrap); end
    endtask

    task automatic test_direction_flip();
        logic [N-1:0] expQ [4] = '{4'd5, 4'd4, 4'd5, 4'd4};
        load = 1; d = 4'd4;
        tick();
        load = 0;
        checks++; if (q !== 4'd4) begin errors++; $display("[TB] FAIL flip_load got %0d expected 4", q); end
        en = 1;
        for (int i = 0; i < 4; i++) begin
            up = (i % 2 == 0);
            tick();
            checks++; if (q !== expQ[i] || wrap !== 1'b0) begin errors++; $display("[TB] FAIL flip step %0d got q=%0d wrap=%0b expected q=%0d wrap=0", i, q, wrap, expQ[i]); end
        end
        en = 0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_count_up();
        test_count_down_clear();
        test_back_to_back();
        test_priority();
        test_async_reset();
        test_direction_flip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
